// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with a 2-entry skid
// buffer. It carries a control field and a data field. in_ready comes
// straight from a flop. flush kills every held entry and forces the
// control field back to its bubble value.
//
// Optional feature macro: PIPE_STAGE_STATS_EN adds the stall_cnt port.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous kill of all held entries
//   in_valid   upstream entry present
//   in_ready   stage can accept this cycle (registered)
//   in_ctrl    upstream control field
//   in_data    upstream data field
//   out_valid  entry presented downstream
//   out_ready  downstream accepts this cycle
//   out_ctrl   control field; CTRL_BUBBLE when out_valid=0
//   out_data   data field
//   stall_cnt  saturating backpressure counter (PIPE_STAGE_STATS_EN only)
module pipe_stage_skid #(
  parameter int unsigned         CTRL_W      = 4,
  parameter int unsigned         DATA_W      = 133,
  parameter logic [CTRL_W-1:0]   CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;

  logic in_xfer;
  logic out_xfer;

  assign out_valid = (state_q != S_EMPTY);
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic; flush overrides every transfer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (in_xfer) state_d = S_FULL;
      S_FULL: begin
        if (out_xfer && !in_xfer)      state_d = S_EMPTY;
        else if (!out_xfer && in_xfer) state_d = S_SKID;
      end
      S_SKID:  if (out_xfer) state_d = S_FULL;
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
    // Registered ready: accept next cycle unless both slots will be full
    in_ready_d = (state_d != S_SKID);
  end

  // Datapath load decode
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Data is deliberately left untouched; only control drops to bubble
      main_ctrl_d = CTRL_BUBBLE;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        S_FULL: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_xfer) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end
        end
        S_SKID: begin
          if (out_xfer) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Output logic
  always_comb begin
    in_ready = in_ready_q;
    out_ctrl = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    out_data = main_data_q;
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic valid/ready pipeline stage register.
- Successor to the fixed-width, never-stalling inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS-32 core.
- Carries a control field and a data field, each with its own parameterised width.
- Adds backpressure through a 2-entry skid buffer, so in_ready is driven from a register only.
- Flush clears the control field to its bubble value and discards all held entries.

Parameters:
- CTRL_W, 4: width of the control field (RegWrite/MemtoReg/MemWrite/hilowrite-style bits); cleared by flush.
- DATA_W, 133: width of the data field (alu result, store data, write reg, hilo result); not cleared by flush.
- CTRL_BUBBLE, {CTRL_W{1'b0}}: control value presented while out_valid=0 and after flush.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle; registered
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream data field
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control field; CTRL_BUBBLE when out_valid=0
- out_data  out  DATA_W  data field
- stall_cnt  out  16  saturating backpressure counter; present only with PIPE_STAGE_STATS_EN

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, skid entry empty, in_ready=1, stall_cnt=0.
- Transfers: an input transfer occurs when in_valid&in_ready; an output transfer occurs when out_valid&out_ready.
- Storage: main register (drives the outputs) plus one skid register.
- State EMPTY (main invalid, skid invalid):
  - input transfer -> FULL, main<=input.
- State FULL (main valid, skid invalid):
  - output transfer and no input transfer -> EMPTY.
  - output transfer and input transfer -> FULL, main<=input.
  - no output transfer and input transfer -> SKID, skid<=input.
- State SKID (main valid, skid valid), in_ready=0:
  - output transfer -> FULL, main<=skid.
- in_ready is registered and equals 1 exactly when the next state is not SKID. It never depends combinationally on out_ready.
- Latency: 1 cycle from input transfer to out_valid when empty. Throughput is 1 entry per cycle while out_ready=1.
- Ordering: strict FIFO. No entry is duplicated or dropped except on flush.
- flush=1 at an edge:
  - next state EMPTY; out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1.
  - out_data keeps its value.
  - any input offered in that same cycle is discarded, even if in_ready=1.
  - flush has priority over every transfer.
- out_ctrl is forced to CTRL_BUBBLE whenever out_valid=0, so downstream may decode ctrl without qualifying it by valid.
- Reset asserted mid-operation: all entries are lost immediately; outputs go to reset values without waiting for a clock edge.
- Data field: held stable while out_valid&!out_ready (standard valid/ready stability rule).

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 each cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared only by reset; flush does not clear it.
- Undefined: port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, idle inputs -> out_valid=0, out_ctrl=4'b0000, out_data=0, in_ready=1.
- Back-to-back streaming:
  - stimulus: out_ready=1; in_valid=1 with ctrl=4'b1010, data=1..8 on consecutive cycles.
  - response: out_data=1..8 on cycles 1..8 after the first input, out_valid continuous, in_ready always 1.
- Backpressure with skid fill:
  - stimulus: entries A=5, B=6 while out_ready=0; then C=7 offered.
  - response: in_ready falls to 0 after B; C is held upstream. After out_ready=1, outputs are 5, 6, 7 in order with no loss.
- Flush while in SKID with in_valid=1, ctrl=4'b1111:
  - next cycle: out_valid=0, out_ctrl=4'b0000, in_ready=1.
  - the offered entry never appears at the output.
- Async reset pulse mid-stream with no clock edge -> out_valid=0 and in_ready=1 immediately.
- PIPE_STAGE_STATS_EN defined:
  - 70000 cycles of out_valid=1, out_ready=0 -> stall_cnt=16'hFFFF.
  - flush -> stall_cnt unchanged.
  - reset -> stall_cnt=0.
